// File: rtl/inv_stream_pkg.sv
// rtl/inv_stream_pkg.sv - shared types and helpers for the inv_stream streaming transform core
//
// Contents:
//   mode_e    transform mode enum (MODE_MASK, MODE_PASS, MODE_REV, MODE_ACC)
//   mode_t    raw 2-bit mode type as carried on the in_mode port
//   bit_rev() reverses the low w bits of a word (w <= REV_MAX_W)
package inv_stream_pkg;

    typedef enum logic [1:0] {
        MODE_MASK = 2'b00,
        MODE_PASS = 2'b01,
        MODE_REV  = 2'b10,
        MODE_ACC  = 2'b11
    } mode_e;

    typedef logic [1:0] mode_t;

    // Widest word bit_rev() can handle; callers narrow the result with a size cast.
    localparam int REV_MAX_W = 64;

    // Reverse the full REV_MAX_W-bit word, then shift so the reversed low w
    // bits land back at bit 0.
    function automatic logic [REV_MAX_W-1:0] bit_rev(input logic [REV_MAX_W-1:0] d,
                                                      input int                   w);
        logic [REV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < REV_MAX_W; i++) begin
            r[i] = d[REV_MAX_W-1-i];
        end
        return r >> (REV_MAX_W - w);
    endfunction

endpackage

// File: rtl/inv_stream_fifo.sv
// rtl/inv_stream_fifo.sv - register-based first-word-fall-through FIFO with occupancy count
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears storage too)
//   clr         synchronous clear of pointers and level (storage kept)
//   push, pop   write / read strobes; caller guarantees no push when full, no pop when empty
//   wr_data     word written on push
//   rd_data     word at the read pointer
//   level       occupancy 0..DEPTH
module inv_stream_fifo
    import inv_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/inv_stream_core.sv
// rtl/inv_stream_core.sv - streaming per-word bit-transform engine with output FIFO
//
// Optional feature: define INV_STREAM_CNT_EN to build the saturating popped-word
// counter; otherwise word_cnt is tied to zero.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   ena                   run enable; low freezes all state and deasserts both handshakes
//   clr                   synchronous clear of FIFO and accumulator
//   in_data/in_mask       input word and per-bit mask
//   in_mode               transform mode (see inv_stream_pkg::mode_e)
//   in_valid/in_ready     input handshake
//   out_data/out_valid    FIFO head word and its valid
//   out_ready             consumer accepts the head word
//   level                 FIFO occupancy 0..DEPTH
//   word_cnt              popped-word count (zero unless INV_STREAM_CNT_EN)
module inv_stream_core
    import inv_stream_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [WIDTH-1:0]         in_mask,
    input  logic [1:0]               in_mode,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              word_cnt
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    mode_t            mode_raw;
    mode_e            mode;
    logic             push;
    logic             pop;
    logic             fifo_clr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] inv_data;
    logic [WIDTH-1:0] rev_data;
    logic [WIDTH-1:0] xform;

    assign mode_raw = in_mode;
    assign mode     = mode_e'(mode_raw);

    // No bypass: a full FIFO refuses input even when the head is popped this cycle.
    assign in_ready  = rst_n && ena && !clr && (level != FULL_LVL);
    assign out_valid = ena && (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // clr only acts while running so that ena low freezes everything.
    assign fifo_clr  = clr && ena;

    assign inv_data = ~in_data;
    assign rev_data = WIDTH'(bit_rev(REV_MAX_W'(inv_data), WIDTH));
    assign acc_n    = acc ^ in_data;

    always_comb begin
        xform = in_data ^ in_mask;
        case (mode)
            MODE_MASK: xform = in_data ^ in_mask;
            MODE_PASS: xform = in_data;
            MODE_REV:  xform = rev_data;
            MODE_ACC:  xform = acc_n ^ in_mask;
            default:   xform = in_data ^ in_mask;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (fifo_clr) begin
            acc <= '0;
        end else if (push && (mode == MODE_ACC)) begin
            acc <= acc_n;
        end
    end

    inv_stream_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (fifo_clr),
        .push    (push),
        .pop     (pop),
        .wr_data (xform),
        .rd_data (out_data),
        .level   (level)
    );

`ifdef INV_STREAM_CNT_EN
    // Counts completed pops; survives clr, cleared only by reset, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (pop && !fifo_clr && (word_cnt != 16'hFFFF)) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
`else
    assign word_cnt = '0;
`endif

endmodule

// File: tb/tb_inv_stream_core.sv
// tb/tb_inv_stream_core.sv - self-checking bench for inv_stream_core
module tb_inv_stream_core;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    localparam logic [1:0] M_MASK = 2'b00;
    localparam logic [1:0] M_PASS = 2'b01;
    localparam logic [1:0] M_REV  = 2'b10;
    localparam logic [1:0] M_ACC  = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             ena;
    logic             clr;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] in_mask;
    logic [1:0]       in_mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [2:0]       level;
    logic [15:0]      word_cnt;

    inv_stream_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .clr       (clr),
        .in_data   (in_data),
        .in_mask   (in_mask),
        .in_mode   (in_mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .word_cnt  (word_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] data;
        logic [7:0] mask;
        logic [7:0] exp;
    } vec_t;

    vec_t       vecs [11];
    int         total = 0;
    int         bad   = 0;
    int         mpops = 0;
    int         mlevel = 0;
    logic [7:0] q [$];
    logic [7:0] feed;
    bit         pushed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single word through an empty FIFO: one-cycle latency, then pop it.
    task automatic push_word(input logic [1:0] m, input logic [7:0] d, input logic [7:0] mk,
                             input logic [7:0] exp, input string tag);
        @(negedge clk);
        in_mode  = m;
        in_data  = d;
        in_mask  = mk;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " out_data"}, 32'(out_data), 32'(exp));
        check({tag, " level"}, 32'(level), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        mpops++;
        #1;
        check({tag, " level after pop"}, 32'(level), 32'd0);
    endtask

    // One cycle of PASS-mode streaming against the bench's own FIFO model.
    task automatic step(output bit did_push);
        bit exp_ir;
        bit exp_ov;
        bit do_pop;
        #1;
        exp_ir = ena && (mlevel != DEPTH);
        exp_ov = ena && (mlevel != 0);
        check("stream in_ready", 32'(in_ready), 32'(exp_ir));
        check("stream out_valid", 32'(out_valid), 32'(exp_ov));
        check("stream level", 32'(level), 32'(mlevel));
        do_pop   = exp_ov && out_ready;
        did_push = in_valid && exp_ir;
        if (do_pop) begin
            check("stream out_data", 32'(out_data), 32'(q[0]));
            void'(q.pop_front());
            mpops++;
        end
        if (did_push) q.push_back(in_data);
        mlevel = mlevel + (did_push ? 1 : 0) - (do_pop ? 1 : 0);
        @(negedge clk);
    endtask

    task automatic stream(input int n);
        for (int c = 0; c < n; c++) begin
            in_data = feed;
            step(pushed);
            if (pushed) feed = feed + 8'h11;
        end
    endtask

    initial begin
        vecs[0]  = '{M_MASK, 8'hA5, 8'hFF, 8'h5A};
        vecs[1]  = '{M_REV,  8'h03, 8'h00, 8'h3F};
        vecs[2]  = '{M_PASS, 8'h3C, 8'hFF, 8'h3C};
        vecs[3]  = '{M_MASK, 8'h0F, 8'h33, 8'h3C};
        vecs[4]  = '{M_ACC,  8'h01, 8'h00, 8'h01};
        vecs[5]  = '{M_ACC,  8'h02, 8'h00, 8'h03};
        vecs[6]  = '{M_ACC,  8'h04, 8'h00, 8'h07};
        vecs[7]  = '{M_ACC,  8'h08, 8'hF0, 8'hFF};
        vecs[8]  = '{M_REV,  8'h80, 8'h00, 8'hFE};
        vecs[9]  = '{M_MASK, 8'h00, 8'h00, 8'h00};
        vecs[10] = '{M_ACC,  8'h10, 8'h00, 8'h1F};

        rst_n = 1'b0; ena = 1'b1; clr = 1'b0;
        in_data = '0; in_mask = '0; in_mode = M_MASK; in_valid = 1'b0; out_ready = 1'b0;

        @(negedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out_data", 32'(out_data), 32'd0);
        check("reset level", 32'(level), 32'd0);
        check("reset word_cnt", 32'(word_cnt), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 11; i++) begin
            push_word(vecs[i].mode, vecs[i].data, vecs[i].mask, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // clr drops a buffered word and the accumulator.
        @(negedge clk);
        in_mode = M_PASS; in_data = 8'h77; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("pre-clr level", 32'(level), 32'd1);
        clr = 1'b1;
        #1;
        check("clr in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("post-clr level", 32'(level), 32'd0);
        check("post-clr out_valid", 32'(out_valid), 32'd0);
        push_word(M_ACC, 8'h10, 8'h00, 8'h10, "acc after clr");

        // Fill to DEPTH with consumer stalled, extra in_valid ignored, then drain with wrap.
        @(negedge clk);
        mlevel = 0;
        in_mode = M_PASS; in_mask = 8'hFF; in_valid = 1'b1; out_ready = 1'b0; feed = 8'h11;
        stream(6);
        #1;
        check("full level", 32'(level), 32'd4);
        check("full in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        stream(8);
        in_valid = 1'b0;
        stream(6);

        // ena low mid-stream freezes everything, including the accumulator.
        in_valid = 1'b1; out_ready = 1'b0;
        stream(2);
        out_ready = 1'b1;
        stream(2);
        ena = 1'b0; in_mode = M_ACC;
        stream(3);
        ena = 1'b1; in_mode = M_PASS;
        stream(4);
        in_valid = 1'b0;
        stream(4);
        out_ready = 1'b0;
        push_word(M_ACC, 8'h01, 8'h00, 8'h11, "acc after ena freeze");

        @(negedge clk);
        #1;
`ifdef INV_STREAM_CNT_EN
        check("word_cnt", 32'(word_cnt), 32'(mpops));
`else
        check("word_cnt", 32'(word_cnt), 32'd0);
`endif

        // Asynchronous reset with words buffered.
        in_mode = M_PASS; in_valid = 1'b1; out_ready = 1'b0;
        stream(2);
        #1;
        check("pre-reset level", 32'(level), 32'd2);
        rst_n = 1'b0;
        #1;
        check("async reset level", 32'(level), 32'd0);
        check("async reset out_valid", 32'(out_valid), 32'd0);
        check("async reset out_data", 32'(out_data), 32'd0);
        check("async reset word_cnt", 32'(word_cnt), 32'd0);
        check("async reset in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("after reset level", 32'(level), 32'd0);
        check("after reset in_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_stream_core.md
# inv_stream_core

Parametrised successor to the board-level inverter: a streaming bit-transform engine for TinyTapeout tiles. Each accepted word is transformed by a per-word mode (masked invert, pass, invert-and-reverse, running-XOR accumulate) and buffered in a small FIFO with valid/ready handshakes on both sides. A `tt_um_*` top wraps it with WIDTH=8, mapping `ui_in` to data and `uio_in` to mask/mode/control.

## Interface
Parameters:
- WIDTH, 8, data/mask width in bits (≥2)
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  high = run; low = freeze all state
- clr  in  1  synchronous clear of FIFO and accumulator
- in_data  in  WIDTH  input word
- in_mask  in  WIDTH  per-bit invert mask, sampled with in_data
- in_mode  in  2  transform mode, sampled with in_data
- in_valid  in  1  producer has a word
- in_ready  out  1  core can accept
- out_data  out  WIDTH  FIFO head word
- out_valid  out  1  out_data is valid
- out_ready  in  1  consumer takes the word
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
- word_cnt  out  16  popped-word count (see Configuration)

## Operation
- Push when in_valid && in_ready; pop when out_valid && out_ready.
- in_ready = ena && !clr && (level != DEPTH). No bypass: a full FIFO never accepts, even on a same-cycle pop.
- out_valid = ena && (level != 0); out_data = mem[rd_ptr] (first-word-fall-through, driven from registers).
- Transform at push, result written to FIFO:
  - MODE_MASK 2'b00: in_data ^ in_mask
  - MODE_PASS 2'b01: in_data (mask ignored)
  - MODE_REV 2'b10: bit-reverse(~in_data)
  - MODE_ACC 2'b11: acc_n = acc ^ in_data; stored = acc_n ^ in_mask; acc <= acc_n
- acc updates only on MODE_ACC pushes; other modes leave it unchanged.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- clr: level, pointers and acc go to 0 next edge; any push/pop in that cycle is discarded; word_cnt is not cleared.
- ena low: no push, pop, acc or counter update; outputs other than in_ready/out_valid hold.

## Timing
- Reset values: in_ready 0 while rst_n low, then 1 (ena high, not full); out_valid 0, out_data 0, level 0, word_cnt 0, acc 0, all memory entries 0.
- Latency: word pushed at edge N is visible on out_data with out_valid=1 after edge N when the FIFO was empty (one cycle).
- Throughput: one word per cycle sustained when out_ready is held high.
- level updates on the same edge as the push/pop.
- Reset asserted mid-transfer drops all buffered words immediately (asynchronous); no partial state survives.

## Configuration
- INV_STREAM_CNT_EN defined: word_cnt increments on each pop, saturates at 16'hFFFF, cleared only by rst_n.
- Not defined: word_cnt tied to 0, counter logic absent.

## Structure
- Package inv_stream_pkg: mode enum (MODE_MASK, MODE_PASS, MODE_REV, MODE_ACC), 2-bit mode type, bit-reverse function parametrised on WIDTH.
- Sub-module inv_stream_fifo (WIDTH, DEPTH): storage, pointers, level, push/pop/clr. Transform and accumulator stay in inv_stream_core.

## Test plan
- Reset, then MODE_MASK push 8'hA5 with mask 8'hFF -> next cycle out_valid=1, out_data=8'h5A, level=1.
- MODE_REV push 8'b0000_0011 -> out_data 8'b0011_1111; MODE_PASS 8'h3C with mask 8'hFF -> 8'h3C.
- MODE_ACC pushes 8'h01, 8'h02, 8'h04 with mask 0 -> outputs 8'h01, 8'h03, 8'h07; clr, then push 8'h10 -> 8'h10.
- out_ready=0, push 4 words (DEPTH=4) -> level=4, in_ready=0; fifth in_valid ignored; then out_ready=1 with in_valid=1 -> words pop in order, pointers wrap, no loss or duplication.
- Toggle ena low mid-stream with in_valid=out_ready=1 -> in_ready=0, out_valid=0, level and acc frozen; ena high resumes with identical data order.
- With INV_STREAM_CNT_EN: 10 pops -> word_cnt=10; assert rst_n low mid-stream -> level=0, out_valid=0, word_cnt=0 immediately.
